// File: rtl/pre_if_stage_pkg.sv
// Shared types and constants for the pre-IF fetch stage.
// No logic; widths, bus field offsets and the redirect priority helper.
// Imported by pre_if_stage and pf_redirect_buf.
package pre_if_stage_pkg;

  localparam int BR_BUS_WD       = 35;
  localparam int PF_TO_FS_BUS_WD = 34;

  // br_bus = {ds_br_or_jump_op, br_stall, br_taken, br_target}
  localparam int BR_OP_BIT    = 34;
  localparam int BR_STALL_BIT = 33;
  localparam int BR_TAKEN_BIT = 32;

  localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;
  localparam logic [31:0] EX_ENTRY_DEF = 32'hbfc00380;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_REQ,
    PF_EXC,
    PF_HALT
  } pf_state_e;

  typedef struct packed {
    logic        drop;
    logic        ex;
    logic [31:0] pc;
  } pf_to_fs_t;

  // Redirect priority: exception > eret > taken branch > fallback.
  function automatic logic [31:0] pick_redirect(
    input logic        ex,
    input logic        eret,
    input logic [31:0] epc,
    input logic        br,
    input logic [31:0] tgt,
    input logic [31:0] ex_entry,
    input logic [31:0] fallback
  );
    if (ex)        return ex_entry;
    else if (eret) return epc;
    else if (br)   return tgt;
    else           return fallback;
  endfunction

endpackage

// File: rtl/pre_if_stage_pf_redirect_buf.sv
// Holds one redirect that could not be issued immediately, plus the drop flag of the pending fetch.
// Latency: captured redirect visible the cycle after capture; drop_o is combinational in the hit cycle.
// Backpressure: none; the top decides when capture or consume happens.
module pf_redirect_buf
  import pre_if_stage_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY = EX_ENTRY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_ex_i,
  input  logic        ws_eret_i,
  input  logic        br_taken_i,
  input  logic [31:0] cp0_epc_i,
  input  logic [31:0] br_target_i,
  input  logic        capture_i,
  input  logic        consume_i,
  input  logic        start_i,
  input  logic        pending_i,
  output logic        redir_v_o,
  output logic [31:0] redir_pc_o,
  output logic        redir_ex_o,
  output logic        drop_o
);

  logic        redir_v_q, redir_v_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        redir_hi_q, redir_hi_d;
  logic        redir_ex_q, redir_ex_d;
  logic        drop_q, drop_d;
  logic        any_redir;
  logic        hi_redir;

  assign any_redir = ws_ex_i | ws_eret_i | br_taken_i;
  assign hi_redir  = ws_ex_i | ws_eret_i;

  // Buffer update: ex/eret always overwrite, a branch never displaces a buffered ex/eret.
  always_comb begin
    redir_v_d  = redir_v_q;
    redir_pc_d = redir_pc_q;
    redir_hi_d = redir_hi_q;
    redir_ex_d = redir_ex_q;
    drop_d     = drop_q;
    if (consume_i) begin
      redir_v_d = 1'b0;
    end else if (capture_i && any_redir && (hi_redir || !(redir_v_q && redir_hi_q))) begin
      redir_v_d  = 1'b1;
      redir_pc_d = pick_redirect(ws_ex_i, ws_eret_i, cp0_epc_i, br_taken_i, br_target_i,
                                 EX_ENTRY, br_target_i);
      redir_hi_d = hi_redir;
      redir_ex_d = ws_ex_i;
    end
    if (start_i) begin
      drop_d = 1'b0;
    end else if (pending_i && any_redir) begin
      drop_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      redir_v_q  <= 1'b0;
      redir_pc_q <= 32'd0;
      redir_hi_q <= 1'b0;
      redir_ex_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      redir_v_q  <= redir_v_d;
      redir_pc_q <= redir_pc_d;
      redir_hi_q <= redir_hi_d;
      redir_ex_q <= redir_ex_d;
      drop_q     <= drop_d;
    end
  end

  assign redir_v_o  = redir_v_q;
  assign redir_pc_o = redir_pc_q;
  assign redir_ex_o = redir_ex_q;
  assign drop_o     = drop_q | (pending_i & any_redir);

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: picks the next fetch PC and runs the sram-like inst request ahead of if_stage.
// Latency: address registered one cycle after the IDLE decision; to_fs_valid in the addr_ok cycle.
// Backpressure: holds req/addr until addr_ok; waits in IDLE while !fs_allowin or br_stall. Option: PF_ADEL_CHECK_EN.
module pre_if_stage
  import pre_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EX_ENTRY = EX_ENTRY_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fs_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  input  logic                       ws_ex,
  input  logic                       ws_eret,
  input  logic [31:0]                cp0_epc,
  output logic                       to_fs_valid,
  output logic [PF_TO_FS_BUS_WD-1:0] pf_to_fs_bus,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic                       inst_sram_addr_ok
);

  pf_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr;
  logic        br_stall, br_taken;
  logic [31:0] br_target;
  logic        issue, pending;
  logic        redir_v, redir_ex, pf_drop, pf_ex;
  logic [31:0] redir_pc;
  pf_to_fs_t   out_bus;

  assign br_stall  = br_bus[BR_STALL_BIT];
  assign br_taken  = br_bus[BR_TAKEN_BIT];
  assign br_target = br_bus[31:0];

  assign fetch_addr = pick_redirect(ws_ex, ws_eret, cp0_epc, br_taken, br_target, EX_ENTRY,
                                    redir_v ? redir_pc : pc_q + 32'd4);
  assign issue   = (state_q == PF_IDLE) && fs_allowin && !br_stall && !reset;
  assign pending = (state_q == PF_REQ) || (state_q == PF_EXC);

  pf_redirect_buf #(.EX_ENTRY(EX_ENTRY)) u_redirect_buf (
    .clk        (clk),
    .reset      (reset),
    .ws_ex_i    (ws_ex),
    .ws_eret_i  (ws_eret),
    .br_taken_i (br_taken),
    .cp0_epc_i  (cp0_epc),
    .br_target_i(br_target),
    .capture_i  (!issue),
    .consume_i  (issue),
    .start_i    (issue),
    .pending_i  (pending),
    .redir_v_o  (redir_v),
    .redir_pc_o (redir_pc),
    .redir_ex_o (redir_ex),
    .drop_o     (pf_drop)
  );

  // Next-state, address latch and handshake decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pc_d        = pc_q;
    to_fs_valid = 1'b0;
    case (state_q)
      PF_IDLE: begin
        if (issue) begin
          addr_d  = fetch_addr;
          state_d = PF_REQ;
`ifdef PF_ADEL_CHECK_EN
          if (fetch_addr[1:0] != 2'b00) state_d = PF_EXC;
`endif
        end
      end
      PF_REQ: begin
        if (inst_sram_addr_ok && !reset) begin
          to_fs_valid = 1'b1;
          pc_d        = addr_q;
          state_d     = PF_IDLE;
        end
      end
`ifdef PF_ADEL_CHECK_EN
      // Misaligned fetch: report it to if_stage without touching the sram.
      PF_EXC: begin
        if (fs_allowin && !reset) begin
          to_fs_valid = 1'b1;
          pc_d        = addr_q;
          state_d     = PF_HALT;
        end
      end
      // Parked until an exception redirect lands in the buffer.
      PF_HALT: begin
        if (redir_v && redir_ex) state_d = PF_IDLE;
      end
`endif
      default: state_d = PF_IDLE;
    endcase
  end

  // FSM and PC registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PF_IDLE;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC - 32'd4;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PF_ADEL_CHECK_EN
  assign pf_ex = (state_q == PF_EXC);
  logic unused_sigs;
  assign unused_sigs = br_bus[BR_OP_BIT];
`else
  assign pf_ex = 1'b0;
  logic unused_sigs;
  assign unused_sigs = ^{br_bus[BR_OP_BIT], redir_ex};
`endif

  assign out_bus.drop = pf_drop;
  assign out_bus.ex   = pf_ex;
  assign out_bus.pc   = addr_q;
  assign pf_to_fs_bus = out_bus;

  assign inst_sram_req   = (state_q == PF_REQ) && !reset;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_addr  = addr_q;
  assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_pre_if_stage.sv
// Self-checking bench for pre_if_stage: scoreboard of expected {drop, ex, pc} handshakes.
// Inputs change 1 time unit after posedge; outputs sampled at negedge or 1 unit after posedge.
// Redirect priority table plus hand-written stall, buffer, drop and reset sequences.
module tb_pre_if_stage;

  logic        clk;
  logic        reset;
  logic        fs_allowin;
  logic [34:0] br_bus;
  logic        ws_ex;
  logic        ws_eret;
  logic [31:0] cp0_epc;
  logic        to_fs_valid;
  logic [33:0] pf_to_fs_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;

  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];

  typedef struct {
    logic        ex;
    logic        eret;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] epc;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs[7];

  pre_if_stage dut (
    .clk              (clk),
    .reset            (reset),
    .fs_allowin       (fs_allowin),
    .br_bus           (br_bus),
    .ws_ex            (ws_ex),
    .ws_eret          (ws_eret),
    .cp0_epc          (cp0_epc),
    .to_fs_valid      (to_fs_valid),
    .pf_to_fs_bus     (pf_to_fs_bus),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_wr     (inst_sram_wr),
    .inst_sram_size   (inst_sram_size),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wdata  (inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (to_fs_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_to_fs_valid: got bus %h expected no handshake", pf_to_fs_bus);
      end else begin
        check("handshake_bus", {30'd0, pf_to_fs_bus}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_redirect(input logic ex, input logic eret, input logic [31:0] epc,
                                input logic br, input logic [31:0] tgt);
    ws_ex   = ex;
    ws_eret = eret;
    cp0_epc = epc;
    br_bus  = {1'b0, 1'b0, br, tgt};
    tick();
    ws_ex   = 1'b0;
    ws_eret = 1'b0;
    br_bus  = '0;
  endtask

  // Expects one request at exp_addr (addr_ok high) and leaves the DUT back in IDLE.
  task automatic fetch_check(input logic [31:0] exp_addr, input logic exp_drop, input logic exp_ex);
    int n = 0;
    exp_q.push_back({exp_drop, exp_ex, exp_addr});
    while (!inst_sram_req && n < 20) begin
      tick();
      n++;
    end
    check("req_addr", {31'd0, inst_sram_req, inst_sram_addr}, {31'd0, 1'b1, exp_addr});
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'hbfc00200, 32'h0,        32'hbfc00380};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'hbfc00500, 32'hbfc00040, 32'hbfc00040};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'hbfc00600, 32'h0,        32'hbfc00600};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'hbfc00040, 32'hbfc00380};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hbfc00384};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'hfffffffc, 32'h0,        32'hfffffffc};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00000000};

    reset = 1'b1;
    fs_allowin = 1'b1;
    br_bus = '0;
    ws_ex = 1'b0;
    ws_eret = 1'b0;
    cp0_epc = '0;
    inst_sram_addr_ok = 1'b1;
    tick();
    tick();
    check("reset_req", {63'd0, inst_sram_req}, 64'd0);
    check("reset_valid", {63'd0, to_fs_valid}, 64'd0);
    check("const_outs", {29'd0, inst_sram_wr, inst_sram_size, inst_sram_wdata}, {29'd0, 1'b0, 2'b10, 32'd0});
    reset = 1'b0;

    // Sequential fetch from reset vector.
    fetch_check(32'hbfc00000, 1'b0, 1'b0);
    fetch_check(32'hbfc00004, 1'b0, 1'b0);
    fetch_check(32'hbfc00008, 1'b0, 1'b0);
    fetch_check(32'hbfc0000c, 1'b0, 1'b0);

    // addr_ok held low 3 cycles: req/addr stable, one handshake on the 4th.
    inst_sram_addr_ok = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 32'hbfc00010});
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_req_addr", {31'd0, inst_sram_req, inst_sram_addr}, {31'd0, 1'b1, 32'hbfc00010});
    end
    inst_sram_addr_ok = 1'b1;
    tick();

    // Branch while request pending: handshake dropped, then branch target fetched.
    inst_sram_addr_ok = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 32'hbfc00014});
    tick();
    pulse_redirect(1'b0, 1'b0, 32'h0, 1'b1, 32'hbfc00100);
    inst_sram_addr_ok = 1'b1;
    tick();
    fetch_check(32'hbfc00100, 1'b0, 1'b0);
    fetch_check(32'hbfc00104, 1'b0, 1'b0);

    // Redirect priority table, each applied in IDLE.
    for (int i = 0; i < 7; i++) begin
      pulse_redirect(vecs[i].ex, vecs[i].eret, vecs[i].epc, vecs[i].br, vecs[i].tgt);
      fetch_check(vecs[i].exp_addr, 1'b0, 1'b0);
    end

    // Branch in IDLE while if_stage not ready: buffered, issued later.
    fs_allowin = 1'b0;
    pulse_redirect(1'b0, 1'b0, 32'h0, 1'b1, 32'hbfc00700);
    tick();
    check("no_req_not_allowin", {63'd0, inst_sram_req}, 64'd0);
    fs_allowin = 1'b1;
    fetch_check(32'hbfc00700, 1'b0, 1'b0);

    // br_stall holds fetch.
    br_bus = {1'b0, 1'b1, 1'b0, 32'h0};
    tick();
    tick();
    check("no_req_br_stall", {63'd0, inst_sram_req}, 64'd0);
    br_bus = '0;
    fetch_check(32'hbfc00704, 1'b0, 1'b0);

    // eret then ex during a pending request: ex wins in the buffer.
    inst_sram_addr_ok = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 32'hbfc00708});
    tick();
    pulse_redirect(1'b0, 1'b1, 32'hbfc00040, 1'b0, 32'h0);
    pulse_redirect(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    inst_sram_addr_ok = 1'b1;
    tick();
    fetch_check(32'hbfc00380, 1'b0, 1'b0);

    // Buffered ex is not displaced by a later branch.
    inst_sram_addr_ok = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 32'hbfc00384});
    tick();
    pulse_redirect(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    pulse_redirect(1'b0, 1'b0, 32'h0, 1'b1, 32'hbfc00800);
    inst_sram_addr_ok = 1'b1;
    tick();
    fetch_check(32'hbfc00380, 1'b0, 1'b0);

    // Redirect in the handshake cycle itself still drops the fetch.
    exp_q.push_back({1'b1, 1'b0, 32'hbfc00384});
    tick();
    br_bus = {1'b0, 1'b0, 1'b1, 32'hbfc00900};
    tick();
    br_bus = '0;
    fetch_check(32'hbfc00900, 1'b0, 1'b0);

    // Reset while a request is pending: addr_ok ignored, restart at reset vector.
    inst_sram_addr_ok = 1'b0;
    tick();
    check("req_before_reset", {32'd0, inst_sram_req, inst_sram_addr[30:0]}, {32'd0, 1'b1, 31'h3fc00904});
    reset = 1'b1;
    inst_sram_addr_ok = 1'b1;
    @(negedge clk);
    check("reset_mid_req_valid", {63'd0, to_fs_valid}, 64'd0);
    tick();
    reset = 1'b0;
    fetch_check(32'hbfc00000, 1'b0, 1'b0);

    // Misaligned eret target.
`ifdef PF_ADEL_CHECK_EN
    exp_q.push_back({1'b0, 1'b1, 32'hbfc00042});
    pulse_redirect(1'b0, 1'b1, 32'hbfc00042, 1'b0, 32'h0);
    check("adel_no_req", {63'd0, inst_sram_req}, 64'd0);
    tick();
    tick();
    check("adel_halt_no_req", {63'd0, inst_sram_req}, 64'd0);
    pulse_redirect(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    fetch_check(32'hbfc00380, 1'b0, 1'b0);
`else
    pulse_redirect(1'b0, 1'b1, 32'hbfc00042, 1'b0, 32'h0);
    fetch_check(32'hbfc00042, 1'b0, 1'b0);
    fetch_check(32'hbfc00046, 1'b0, 1'b0);
`endif

    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
